// File: rtl/key_seq_pkg.sv
// Shared definitions for the key sequence sender: FSM states, default
// 100 MHz timing and the key-line encoding used by the press decoder.
package key_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } seq_state_e;

    localparam int unsigned PRESS_CYC_DEF = 32'd60;
    localparam int unsigned GAP_CYC_DEF   = 32'd10000;

    localparam int unsigned KEY0_BIT = 32'd0;
    localparam int unsigned KEY1_BIT = 32'd1;

    // One-hot key vector for a code bit: 1 selects key1, 0 selects key0.
    function automatic logic [1:0] key_sel(input logic bit_val);
        logic [1:0] v;
        if (bit_val) begin
            v = 2'b01 << KEY1_BIT;
        end else begin
            v = 2'b01 << KEY0_BIT;
        end
        return v;
    endfunction

endpackage

// File: rtl/key_seq_timer.sv
// Loadable down-counter shared by the press and gap phases. It stops at
// zero and raises the zero flag until it is loaded again.
module key_seq_timer #(
    parameter int unsigned CNT_W = 32'd14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins, otherwise decrement until zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= value;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/key_seq_sender.sv
// Replays a stored code as timed press pulses on key0/key1. The code is
// left-aligned at start so the first bit to send (bit len-1) sits at the
// MSB; each completed press/gap shifts the next bit into the MSB.
module key_seq_sender
    import key_seq_pkg::*;
#(
    parameter int unsigned CODE_LEN_MAX = 32'd8,
    parameter int unsigned LEN_W        = 32'd4,
    parameter int unsigned PRESS_CYC    = PRESS_CYC_DEF,
    parameter int unsigned GAP_CYC      = GAP_CYC_DEF,
    parameter int unsigned CNT_W        = 32'd14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CODE_LEN_MAX-1:0] code,
    input  logic [LEN_W-1:0]        len,
    output logic                    key0,
    output logic                    key1,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_W-1:0]        sent_cnt
);

    localparam logic [LEN_W-1:0] LEN_MAX_C  = LEN_W'(CODE_LEN_MAX);
    localparam logic [LEN_W-1:0] LEN_ONE_C  = LEN_W'(1'b1);
    localparam logic [CNT_W-1:0] PRESS_LD_C = CNT_W'(PRESS_CYC - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LD_C   = CNT_W'(GAP_CYC - 32'd1);

    seq_state_e              state_r;
    seq_state_e              state_nxt_s;
    logic [CODE_LEN_MAX-1:0] shift_r;
    logic [CODE_LEN_MAX-1:0] shift_nxt_s;
    logic [CODE_LEN_MAX-1:0] aligned_s;
    logic [CODE_LEN_MAX-1:0] shifted_s;
    logic [LEN_W-1:0]        len_r;
    logic [LEN_W-1:0]        len_nxt_s;
    logic [LEN_W-1:0]        len_clamp_s;
    logic [LEN_W-1:0]        sent_cnt_r;
    logic [LEN_W-1:0]        sent_cnt_nxt_s;
    logic [1:0]              keys_r;
    logic [1:0]              keys_nxt_s;
    logic                    busy_r;
    logic                    busy_nxt_s;
    logic                    done_r;
    logic                    done_nxt_s;
    logic                    last_press_s;
    logic                    tmr_load_s;
    logic [CNT_W-1:0]        tmr_val_s;
    logic                    tmr_zero_s;

    key_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load_s),
        .value (tmr_val_s),
        .zero  (tmr_zero_s)
    );

    // Clamp the requested length and left-align the code for MSB-first replay.
    always_comb begin
        if (len > LEN_MAX_C) begin
            len_clamp_s = LEN_MAX_C;
        end else begin
            len_clamp_s = len;
        end
        aligned_s    = code << (LEN_MAX_C - len_clamp_s);
        shifted_s    = shift_r << 1'b1;
        last_press_s = ((sent_cnt_r + LEN_ONE_C) == len_r);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; abort cancels PRESS/GAP and beats start in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (start) begin
                    if (len_clamp_s == {LEN_W{1'b0}}) begin
                        state_nxt_s = FIN;
                    end else begin
                        state_nxt_s = PRESS;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (tmr_zero_s) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = PRESS;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (tmr_zero_s) begin
                    if (last_press_s) begin
                        state_nxt_s = FIN;
                    end else begin
                        state_nxt_s = PRESS;
                    end
                end else begin
                    state_nxt_s = GAP;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath, plus timer loads.
    always_comb begin
        shift_nxt_s    = shift_r;
        len_nxt_s      = len_r;
        sent_cnt_nxt_s = sent_cnt_r;
        keys_nxt_s     = keys_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        tmr_load_s     = 1'b0;
        tmr_val_s      = {CNT_W{1'b0}};
        case (state_r)
            IDLE: begin
                keys_nxt_s = 2'b00;
                busy_nxt_s = 1'b0;
                if (!abort && start) begin
                    shift_nxt_s    = aligned_s;
                    len_nxt_s      = len_clamp_s;
                    sent_cnt_nxt_s = {LEN_W{1'b0}};
                    if (len_clamp_s == {LEN_W{1'b0}}) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        busy_nxt_s = 1'b1;
                        keys_nxt_s = key_sel(aligned_s[CODE_LEN_MAX-1]);
                        tmr_load_s = 1'b1;
                        tmr_val_s  = PRESS_LD_C;
                    end
                end else begin
                    shift_nxt_s = shift_r;
                end
            end
            PRESS: begin
                if (abort) begin
                    keys_nxt_s = 2'b00;
                    busy_nxt_s = 1'b0;
                end else if (tmr_zero_s) begin
                    keys_nxt_s = 2'b00;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = GAP_LD_C;
                end else begin
                    keys_nxt_s = keys_r;
                end
            end
            GAP: begin
                if (abort) begin
                    keys_nxt_s = 2'b00;
                    busy_nxt_s = 1'b0;
                end else if (tmr_zero_s) begin
                    sent_cnt_nxt_s = sent_cnt_r + LEN_ONE_C;
                    if (last_press_s) begin
                        busy_nxt_s = 1'b0;
                        done_nxt_s = 1'b1;
                        keys_nxt_s = 2'b00;
                    end else begin
                        shift_nxt_s = shifted_s;
                        keys_nxt_s  = key_sel(shifted_s[CODE_LEN_MAX-1]);
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = PRESS_LD_C;
                    end
                end else begin
                    keys_nxt_s = 2'b00;
                end
            end
            FIN: begin
                keys_nxt_s = 2'b00;
                busy_nxt_s = 1'b0;
            end
            default: begin
                keys_nxt_s = 2'b00;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_r    <= {CODE_LEN_MAX{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            sent_cnt_r <= {LEN_W{1'b0}};
            keys_r     <= 2'b00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            shift_r    <= shift_nxt_s;
            len_r      <= len_nxt_s;
            sent_cnt_r <= sent_cnt_nxt_s;
            keys_r     <= keys_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign key0     = keys_r[KEY0_BIT];
    assign key1     = keys_r[KEY1_BIT];
    assign busy     = busy_r;
    assign done     = done_r;
    assign sent_cnt = sent_cnt_r;

endmodule

// File: tb/tb_key_seq_sender.sv
// Scoreboard bench for key_seq_sender with short timing (press 4, gap 6).
// Stimulus pushes expected press/done events; a negedge monitor rebuilds
// events from the key and done lines and compares them in order.
module tb_key_seq_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] code;
    logic [3:0] len;
    logic       key0;
    logic       key1;
    logic       busy;
    logic       done;
    logic [3:0] sent_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 press, 1 done
        logic [1:0]  key;
        logic [31:0] at;
        logic [31:0] ln;
        logic [3:0]  sent;
    } ev_t;

    ev_t exp_q[$];

    key_seq_sender #(
        .CODE_LEN_MAX (8),
        .LEN_W        (4),
        .PRESS_CYC    (4),
        .GAP_CYC      (6),
        .CNT_W        (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .code     (code),
        .len      (len),
        .key0     (key0),
        .key1     (key1),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter: value seen at a negedge = rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic exp_press(input int key, input int at, input int ln);
        ev_t e;
        e.kind = 2'd0; e.key = key[1:0]; e.at = at; e.ln = ln; e.sent = 4'd0;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int at, input int sent);
        ev_t e;
        e.kind = 2'd1; e.key = 2'd0; e.at = at; e.ln = 0; e.sent = sent[3:0];
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_t g);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d key=%0d at=%0d len=%0d sent=%0d",
                     g.kind, g.key, g.at, g.ln, g.sent);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL event got kind=%0d key=%0d at=%0d len=%0d sent=%0d want kind=%0d key=%0d at=%0d len=%0d sent=%0d",
                         g.kind, g.key, g.at, g.ln, g.sent, e.kind, e.key, e.at, e.ln, e.sent);
            end
        end
    endtask

    logic [1:0] prev_k = 2'b00;
    int         pstart [2];

    // Monitor: key exclusivity each cycle, press end events and done pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t g;
            logic [1:0] cur_k;
            cur_k = {key1, key0};
            checks++;
            if (cur_k === 2'b11) begin
                errors++;
                $display("FAIL key_exclusive got=%b want=not 11 (cyc %0d)", cur_k, cyc);
            end
            for (int k = 0; k < 2; k++) begin
                if (cur_k[k] === 1'b1 && prev_k[k] == 1'b0) begin
                    pstart[k] <= cyc;
                end else if (cur_k[k] !== 1'b1 && prev_k[k] == 1'b1) begin
                    g.kind = 2'd0; g.key = k[1:0]; g.at = pstart[k];
                    g.ln = cyc - pstart[k]; g.sent = 4'd0;
                    observe(g);
                end
            end
            prev_k <= {(cur_k[1] === 1'b1), (cur_k[0] === 1'b1)};
            if (done !== 1'b0) begin
                g.kind = 2'd1; g.key = 2'd0; g.at = cyc; g.ln = 0; g.sent = sent_cnt;
                observe(g);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] c, input logic [3:0] l);
        code  = c;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cs;
        int ck[8];
        ck = '{1, 0, 1, 1, 0, 0, 0, 1};

        // Reset held with start asserted.
        rst = 1'b0; start = 1'b1; abort = 1'b0; code = 8'hFF; len = 4'd5;
        tick(3);
        chk("rst_key0", key0, 0);
        chk("rst_key1", key1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", sent_cnt, 0);
        rst = 1'b1; start = 1'b0;
        tick(1);
        chk("idle_busy", busy, 0);
        chk("idle_keys", {key1, key0}, 0);
        mon_en = 1'b1;
        tick(1);

        // Unlock pattern 00010010, len 5: key1,key0,key0,key1,key0.
        cs = cyc + 1;
        exp_press(1, cs, 4); exp_press(0, cs + 10, 4); exp_press(0, cs + 20, 4);
        exp_press(1, cs + 30, 4); exp_press(0, cs + 40, 4); exp_done(cs + 50, 5);
        pulse_start(8'b00010010, 4'd5);
        code = 8'hFF; len = 4'd1;
        chk("unlock_busy_first", busy, 1);
        tick(49);
        chk("unlock_busy_last", busy, 1);
        tick(1);
        chk("unlock_busy_end", busy, 0);
        tick(2);
        chk("unlock_sent", sent_cnt, 5);

        // len = 0: done right away, no keys, busy stays low.
        cs = cyc + 1;
        exp_done(cs, 0);
        pulse_start(8'hAA, 4'd0);
        chk("len0_busy", busy, 0);
        chk("len0_sent", sent_cnt, 0);
        tick(1);
        chk("len0_busy2", busy, 0);
        chk("len0_done_off", done, 0);
        tick(3);

        // Abort during the third press.
        cs = cyc + 1;
        exp_press(1, cs, 4); exp_press(1, cs + 10, 4); exp_press(1, cs + 20, 3);
        pulse_start(8'hFF, 4'd8);
        tick(22);
        chk("abort_key1_before", key1, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_key1", key1, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sent", sent_cnt, 2);
        chk("abort_done", done, 0);
        tick(5);
        chk("abort_sent_hold", sent_cnt, 2);

        // Abort together with start in IDLE: start dropped.
        code = 8'h0F; len = 4'd3; abort = 1'b1; start = 1'b1;
        tick(1);
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", busy, 0);
        tick(1);
        chk("abort_start_keys", {key1, key0}, 0);
        chk("abort_start_sent", sent_cnt, 2);

        // Start during gap is ignored: 101 with len 3 runs unchanged.
        cs = cyc + 1;
        exp_press(1, cs, 4); exp_press(0, cs + 10, 4); exp_press(1, cs + 20, 4);
        exp_done(cs + 30, 3);
        pulse_start(8'b00000101, 4'd3);
        tick(5);
        pulse_start(8'hFF, 4'd8);
        tick(26);
        chk("retrig_sent", sent_cnt, 3);
        chk("retrig_busy", busy, 0);

        // len 15 clamps to 8 presses.
        cs = cyc + 1;
        for (int i = 0; i < 8; i++) exp_press(ck[i], cs + 10 * i, 4);
        exp_done(cs + 80, 8);
        pulse_start(8'b10110001, 4'd15);
        tick(81);
        chk("clamp_sent", sent_cnt, 8);
        chk("clamp_busy", busy, 0);

        // Reset during the second gap, then a full rerun.
        cs = cyc + 1;
        exp_press(1, cs, 4); exp_press(1, cs + 10, 4);
        pulse_start(8'b00000110, 4'd3);
        tick(15);
        chk("midrst_busy_before", busy, 1);
        rst = 1'b0;
        tick(1);
        chk("midrst_key0", key0, 0);
        chk("midrst_key1", key1, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sent", sent_cnt, 0);
        rst = 1'b1;
        tick(1);
        cs = cyc + 1;
        exp_press(1, cs, 4); exp_press(1, cs + 10, 4); exp_press(0, cs + 20, 4);
        exp_done(cs + 30, 3);
        pulse_start(8'b00000110, 4'd3);
        tick(32);
        chk("rerun_sent", sent_cnt, 3);
        tick(2);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
